// File: rtl/datapath_seq.sv
// Five-state sequenced datapath: register file, A/B operand latches, shift + ALU,
// result register C and Z/N/V status, one command per IDLE->LOADA->LOADB->EXEC->WB pass.
module datapath_seq #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    localparam int RW = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_kind,
    input  logic [RW-1:0]    rd,
    input  logic [RW-1:0]    rn,
    input  logic [RW-1:0]    rm,
    input  logic [1:0]       alu_op,
    input  logic [1:0]       shift,
    input  logic             bsel,
    input  logic [WIDTH-1:0] imm,
    output logic [WIDTH-1:0] datapath_out,
    output logic             Z_out,
    output logic             N_out,
    output logic             V_out,
    output logic             done,
    output logic             busy,
    input  logic [RW-1:0]    dbg_readnum,
    output logic [WIDTH-1:0] dbg_data
);

    localparam logic [1:0] KIND_ALU  = 2'b00;
    localparam logic [1:0] KIND_MOVI = 2'b01;
    localparam logic [1:0] KIND_CMP  = 2'b10;
    localparam logic [1:0] KIND_MOV  = 2'b11;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_NOT = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOADA = 3'd1,
        ST_LOADB = 3'd2,
        ST_EXEC  = 3'd3,
        ST_WB    = 3'd4
    } state_t;

    function automatic logic [WIDTH-1:0] shift_fn(input logic [1:0] sh, input logic [WIDTH-1:0] val);
        case (sh)
            2'b00:   shift_fn = val;
            2'b01:   shift_fn = {val[WIDTH-2:0], 1'b0};
            2'b10:   shift_fn = {1'b0, val[WIDTH-1:1]};
            2'b11:   shift_fn = {val[WIDTH-1], val[WIDTH-1:1]};
            default: shift_fn = val;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] alu_fn(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        case (op)
            OP_ADD:  alu_fn = a + b;
            OP_SUB:  alu_fn = a - b;
            OP_AND:  alu_fn = a & b;
            OP_NOT:  alu_fn = ~b;
            default: alu_fn = a + b;
        endcase
    endfunction

    // Two's-complement overflow: add overflows when like-signed operands give an
    // opposite-signed result; sub when unlike-signed operands flip the sign of A.
    function automatic logic ovf_fn(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                    input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] r);
        case (op)
            OP_ADD:  ovf_fn = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            OP_SUB:  ovf_fn = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            default: ovf_fn = 1'b0;
        endcase
    endfunction

    state_t           state_r;
    state_t           state_next_s;
    logic             accept_s;
    logic             ready_next_s;
    logic             busy_next_s;
    logic             done_next_s;

    logic             ready_r;
    logic             busy_r;
    logic             done_r;

    logic [1:0]       kind_r;
    logic [RW-1:0]    rd_r;
    logic [RW-1:0]    rn_r;
    logic [RW-1:0]    rm_r;
    logic [1:0]       op_r;
    logic [1:0]       shift_r;
    logic             bsel_r;
    logic [WIDTH-1:0] imm_r;

    logic [WIDTH-1:0] regs_r [NREGS];
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] c_r;
    logic             z_r;
    logic             n_r;
    logic             v_r;

    logic [WIDTH-1:0] bop_s;
    logic [WIDTH-1:0] alu_res_s;
    logic             alu_v_s;
    logic [WIDTH-1:0] c_next_s;
    logic             flags_upd_s;
    logic             wr_en_s;

    assign accept_s = cmd_valid && (state_r == ST_IDLE);

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic: one state per clock, no stalls
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = ST_LOADA;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOADA: state_next_s = ST_LOADB;
            ST_LOADB: state_next_s = ST_EXEC;
            ST_EXEC:  state_next_s = ST_WB;
            ST_WB:    state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // FSM output decode, evaluated on the next state so the outputs can be registered
    always_comb begin
        ready_next_s = 1'b0;
        busy_next_s  = 1'b0;
        done_next_s  = 1'b0;
        case (state_next_s)
            ST_IDLE:  ready_next_s = 1'b1;
            ST_WB: begin
                busy_next_s = 1'b1;
                done_next_s = 1'b1;
            end
            default:  busy_next_s = 1'b1;
        endcase
    end

    // Registered handshake and status outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            ready_r <= ready_next_s;
            busy_r  <= busy_next_s;
            done_r  <= done_next_s;
        end
    end

    // Command field capture on acceptance; later input changes are ignored
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            kind_r  <= 2'b00;
            rd_r    <= {RW{1'b0}};
            rn_r    <= {RW{1'b0}};
            rm_r    <= {RW{1'b0}};
            op_r    <= 2'b00;
            shift_r <= 2'b00;
            bsel_r  <= 1'b0;
            imm_r   <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            kind_r  <= cmd_kind;
            rd_r    <= rd;
            rn_r    <= rn;
            rm_r    <= rm;
            op_r    <= alu_op;
            shift_r <= shift;
            bsel_r  <= bsel;
            imm_r   <= imm;
        end
    end

    // Execute-stage operand selection, ALU and result/flag selection
    always_comb begin
        bop_s       = bsel_r ? imm_r : shift_fn(shift_r, b_r);
        alu_res_s   = alu_fn(op_r, a_r, bop_s);
        alu_v_s     = ovf_fn(op_r, a_r, bop_s, alu_res_s);
        c_next_s    = c_r;
        flags_upd_s = 1'b0;
        case (kind_r)
            KIND_ALU: begin
                c_next_s    = alu_res_s;
                flags_upd_s = 1'b1;
            end
            KIND_CMP: begin
                c_next_s    = alu_res_s;
                flags_upd_s = 1'b1;
            end
            KIND_MOV:  c_next_s = bop_s;
            KIND_MOVI: c_next_s = imm_r;
            default:   c_next_s = c_r;
        endcase
        if ((state_r == ST_WB) && (kind_r != KIND_CMP)) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Operand, result and status registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a_r <= {WIDTH{1'b0}};
            b_r <= {WIDTH{1'b0}};
            c_r <= {WIDTH{1'b0}};
            z_r <= 1'b0;
            n_r <= 1'b0;
            v_r <= 1'b0;
        end else begin
            if (state_r == ST_LOADA) begin
                a_r <= regs_r[rn_r];
            end
            if (state_r == ST_LOADB) begin
                b_r <= regs_r[rm_r];
            end
            if (state_r == ST_EXEC) begin
                c_r <= c_next_s;
                if (flags_upd_s) begin
                    z_r <= (alu_res_s == {WIDTH{1'b0}});
                    n_r <= alu_res_s[WIDTH-1];
                    v_r <= alu_v_s;
                end
            end
        end
    end

    // Register file with writeback port
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= {WIDTH{1'b0}};
            end
        end else if (wr_en_s) begin
            regs_r[rd_r] <= c_r;
        end
    end

    assign cmd_ready    = ready_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign datapath_out = c_r;
    assign Z_out        = z_r;
    assign N_out        = n_r;
    assign V_out        = v_r;
    assign dbg_data     = regs_r[dbg_readnum];

endmodule

// File: tb/tb_datapath_seq.sv
// Self-checking bench for datapath_seq: vector table with hand-derived results,
// scoreboard queue popped at each done pulse, plus reset and abort sequences.
module tb_datapath_seq;

    localparam int W  = 16;
    localparam int NR = 8;
    localparam int RW = 3;

    typedef struct {
        logic [1:0]    kind;
        logic [RW-1:0] rd;
        logic [RW-1:0] rn;
        logic [RW-1:0] rm;
        logic [1:0]    op;
        logic [1:0]    sh;
        logic          bsel;
        logic [W-1:0]  imm;
        logic [W-1:0]  exp_c;
        logic          ez;
        logic          en;
        logic          ev;
    } vec_t;

    typedef struct {
        logic [W-1:0]  c;
        logic          z;
        logic          n;
        logic          v;
        bit            wr;
        logic [RW-1:0] rd;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_kind;
    logic [RW-1:0] rd, rn, rm;
    logic [1:0]    alu_op;
    logic [1:0]    shift;
    logic          bsel;
    logic [W-1:0]  imm;
    logic [W-1:0]  datapath_out;
    logic          Z_out, N_out, V_out;
    logic          done, busy;
    logic [RW-1:0] dbg_readnum;
    logic [W-1:0]  dbg_data;

    int checks = 0;
    int fails  = 0;

    logic [W-1:0] mregs [NR];
    exp_t         exp_q [$];
    vec_t         vecs  [17];

    always #10 clk = ~clk;

    datapath_seq #(.WIDTH(W), .NREGS(NR)) dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_kind(cmd_kind), .rd(rd), .rn(rn), .rm(rm), .alu_op(alu_op), .shift(shift),
        .bsel(bsel), .imm(imm), .datapath_out(datapath_out), .Z_out(Z_out), .N_out(N_out),
        .V_out(V_out), .done(done), .busy(busy), .dbg_readnum(dbg_readnum), .dbg_data(dbg_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] kind, input logic [RW-1:0] rd_v,
                                input logic [RW-1:0] rn_v, input logic [RW-1:0] rm_v,
                                input logic [1:0] op, input logic [1:0] sh, input logic bs,
                                input logic [W-1:0] im, input logic [W-1:0] c,
                                input logic z, input logic n, input logic v);
        vec_t r;
        r.kind = kind; r.rd = rd_v; r.rn = rn_v; r.rm = rm_v; r.op = op; r.sh = sh;
        r.bsel = bs; r.imm = im; r.exp_c = c; r.ez = z; r.en = n; r.ev = v;
        return r;
    endfunction

    task automatic scramble();
        cmd_kind = 2'($urandom);
        rd       = RW'($urandom);
        rn       = RW'($urandom);
        rm       = RW'($urandom);
        alu_op   = 2'($urandom);
        shift    = 2'($urandom);
        bsel     = 1'($urandom);
        imm      = W'($urandom);
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < NR; i++) begin
            dbg_readnum = RW'(i);
            #1;
            chk($sformatf("%s_R%0d", tag, i), 32'(dbg_data), 32'(mregs[i]));
        end
    endtask

    task automatic check_idle_clear(input string tag);
        chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_out"}, 32'(datapath_out), 32'd0);
        chk({tag, "_flags"}, 32'({Z_out, N_out, V_out}), 32'd0);
        for (int i = 0; i < NR; i++) mregs[i] = 16'h0000;
        check_regs(tag);
    endtask

    // Called at a negedge with the block idle; returns at the negedge after writeback.
    task automatic run_cmd(input string tag, input vec_t v, input bit hammer);
        exp_t e;
        bit   got;
        int   lat;
        chk({tag, "_ready_pre"}, 32'(cmd_ready), 32'd1);
        cmd_kind = v.kind; rd = v.rd; rn = v.rn; rm = v.rm;
        alu_op = v.op; shift = v.sh; bsel = v.bsel; imm = v.imm;
        cmd_valid = 1'b1;
        @(posedge clk);
        e.c = v.exp_c; e.z = v.ez; e.n = v.en; e.v = v.ev;
        e.wr = (v.kind != 2'b10); e.rd = v.rd;
        exp_q.push_back(e);
        #1;
        scramble();
        cmd_valid = hammer;
        got = 1'b0;
        lat = 0;
        for (int k = 1; k <= 8 && !got; k++) begin
            @(negedge clk);
            chk({tag, "_ready_low"}, 32'(cmd_ready), 32'd0);
            if (done) begin
                got = 1'b1;
                lat = k;
            end else begin
                chk({tag, "_busy_high"}, 32'(busy), 32'd1);
            end
            if (hammer) scramble();
        end
        e = exp_q.pop_front();
        if (!got) begin
            chk({tag, "_done_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({tag, "_latency"}, 32'(lat), 32'd4);
            chk({tag, "_result"}, 32'(datapath_out), 32'(e.c));
            chk({tag, "_flags_ZNV"}, 32'({Z_out, N_out, V_out}), 32'({e.z, e.n, e.v}));
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        chk({tag, "_done_pulse_end"}, 32'(done), 32'd0);
        chk({tag, "_ready_after"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
        if (e.wr) mregs[e.rd] = e.c;
        check_regs(tag);
    endtask

    initial begin
        //            kind   rd rn rm op     sh     bs  imm       exp_c     Z  N  V
        vecs[0]  = mk(2'b01, 3, 0, 0, 2'b00, 2'b00, 0, 16'd42,   16'h002A, 0, 0, 0);
        vecs[1]  = mk(2'b01, 5, 0, 0, 2'b00, 2'b00, 0, 16'd13,   16'h000D, 0, 0, 0);
        vecs[2]  = mk(2'b00, 2, 5, 3, 2'b00, 2'b01, 0, 16'h0000, 16'h0061, 0, 0, 0);
        vecs[3]  = mk(2'b10, 6, 3, 3, 2'b01, 2'b00, 0, 16'h0000, 16'h0000, 1, 0, 0);
        vecs[4]  = mk(2'b01, 1, 0, 0, 2'b00, 2'b00, 0, 16'h7FFF, 16'h7FFF, 1, 0, 0);
        vecs[5]  = mk(2'b01, 0, 0, 0, 2'b00, 2'b00, 0, 16'h0001, 16'h0001, 1, 0, 0);
        vecs[6]  = mk(2'b00, 4, 1, 0, 2'b00, 2'b00, 0, 16'h0000, 16'h8000, 0, 1, 1);
        vecs[7]  = mk(2'b11, 7, 0, 4, 2'b00, 2'b11, 0, 16'h0000, 16'hC000, 0, 1, 1);
        vecs[8]  = mk(2'b00, 6, 0, 1, 2'b01, 2'b00, 0, 16'h0000, 16'h8002, 0, 1, 0);
        vecs[9]  = mk(2'b00, 5, 4, 7, 2'b10, 2'b00, 0, 16'h0000, 16'h8000, 0, 1, 0);
        vecs[10] = mk(2'b00, 3, 0, 3, 2'b11, 2'b10, 0, 16'h0000, 16'hFFEA, 0, 1, 0);
        vecs[11] = mk(2'b00, 0, 0, 0, 2'b00, 2'b01, 1, 16'hFFFF, 16'h0000, 1, 0, 0);
        vecs[12] = mk(2'b00, 1, 4, 0, 2'b01, 2'b00, 1, 16'h0001, 16'h7FFF, 0, 0, 1);
        vecs[13] = mk(2'b11, 2, 0, 0, 2'b00, 2'b01, 1, 16'h1234, 16'h1234, 0, 0, 1);
        vecs[14] = mk(2'b00, 2, 2, 2, 2'b00, 2'b00, 0, 16'h0000, 16'h2468, 0, 0, 0);
        vecs[15] = mk(2'b10, 3, 5, 5, 2'b00, 2'b01, 0, 16'h0000, 16'h8000, 0, 1, 0);
        vecs[16] = mk(2'b01, 2, 0, 0, 2'b00, 2'b00, 0, 16'h0005, 16'h0005, 0, 1, 0);

        reset_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_kind = 2'b00; rd = 3'd0; rn = 3'd0; rm = 3'd0;
        alu_op = 2'b00; shift = 2'b00; bsel = 1'b0; imm = 16'h0000;
        dbg_readnum = 3'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        check_idle_clear("reset");

        for (int i = 0; i < 17; i++) begin
            run_cmd($sformatf("vec%0d", i), vecs[i], (i % 2) == 1);
        end

        // Abort an ALU add on R2 (currently 5) by resetting while in EXEC.
        cmd_kind = 2'b00; rd = 3'd2; rn = 3'd2; rm = 3'd2;
        alu_op = 2'b00; shift = 2'b00; bsel = 1'b0; imm = 16'h0000;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_busy_in_exec", 32'(busy), 32'd1);
        chk("abort_no_early_done", 32'(done), 32'd0);
        reset_n = 1'b0;
        @(negedge clk);
        check_idle_clear("abort");
        reset_n = 1'b1;
        @(negedge clk);
        chk("abort_idle_done", 32'(done), 32'd0);
        chk("abort_idle_ready", 32'(cmd_ready), 32'd1);
        chk("abort_idle_busy", 32'(busy), 32'd0);

        run_cmd("recover", mk(2'b01, 6, 0, 0, 2'b00, 2'b00, 0, 16'h00AA, 16'h00AA, 0, 0, 0), 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
